// File: rtl/nor_package_tester_if.sv
// Board-side start/status and device-side gate pins for the quad NOR tester.
// The slave modport is the tester; the master modport is its surroundings.
`timescale 1ns/1ps
interface nor_package_tester_if;
  logic       start;
  logic       abort;
  logic       a1, b1, a2, b2, a3, b3, a4, b4;
  logic       y1, y2, y3, y4;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [8:0] err_count;
  logic [7:0] first_fail_vec;
  logic       first_fail_valid;

  modport slave (
    input  start, abort, y1, y2, y3, y4,
    output a1, b1, a2, b2, a3, b3, a4, b4,
    output busy, done, pass, fail_mask, err_count, first_fail_vec, first_fail_valid
  );

  modport master (
    output start, abort, y1, y2, y3, y4,
    input  a1, b1, a2, b2, a3, b3, a4, b4,
    input  busy, done, pass, fail_mask, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/nor_package_tester.sv
// Exhaustive 256-vector sequencer for a quad 2-input NOR device. Each vector is
// held SETTLE_CYCLES cycles, then the synchronised outputs are compared to NOR.
`timescale 1ns/1ps
module nor_package_tester #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  nor_package_tester_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       vec, vec_nxt;
  logic [7:0]       stim, stim_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             pass, pass_nxt;
  logic [3:0]       mask, mask_nxt;
  logic [8:0]       err, err_nxt;
  logic [7:0]       ffv, ffv_nxt;
  logic             ffvalid, ffvalid_nxt;
  logic [3:0]       y_sync_p0, y_sync_p1;
  logic [3:0]       exp_y, mism;
  logic [8:0]       err_inc;

  // stage p0/p1: two-flop synchroniser for the asynchronous gate outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_sync_p0 <= 4'd0;
      y_sync_p1 <= 4'd0;
    end else begin
      y_sync_p0 <= {bus.y4, bus.y3, bus.y2, bus.y1};
      y_sync_p1 <= y_sync_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    vec_nxt     = vec;
    stim_nxt    = stim;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    pass_nxt    = pass;
    mask_nxt    = mask;
    err_nxt     = err;
    ffv_nxt     = ffv;
    ffvalid_nxt = ffvalid;

    for (int k = 0; k < 4; k++) exp_y[k] = ~(stim[2*k] | stim[2*k+1]);
    mism    = y_sync_p1 ^ exp_y;
    err_inc = err + {8'd0, |mism};

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt   = SETTLE;
          vec_nxt     = 8'd0;
          stim_nxt    = 8'd0;
          cnt_nxt     = SETTLE_LOAD;
          busy_nxt    = 1'b1;
          pass_nxt    = 1'b0;
          mask_nxt    = 4'd0;
          err_nxt     = 9'd0;
          ffv_nxt     = 8'd0;
          ffvalid_nxt = 1'b0;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          stim_nxt  = 8'd0;
          pass_nxt  = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CHECK: begin
        // abort wins: the partial results of earlier vectors are kept as-is
        if (bus.abort) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          stim_nxt  = 8'd0;
          pass_nxt  = 1'b0;
        end else begin
          mask_nxt = mask | mism;
          err_nxt  = err_inc;
          if (mism != 4'd0 && !ffvalid) begin
            ffv_nxt     = vec;
            ffvalid_nxt = 1'b1;
          end
          if (vec == 8'hFF) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            stim_nxt  = 8'd0;
            pass_nxt  = (err_inc == 9'd0);
          end else begin
            state_nxt = SETTLE;
            vec_nxt   = vec + 8'd1;
            stim_nxt  = vec + 8'd1;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec     <= 8'd0;
      stim    <= 8'd0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      mask    <= 4'd0;
      err     <= 9'd0;
      ffv     <= 8'd0;
      ffvalid <= 1'b0;
    end else begin
      vec     <= vec_nxt;
      stim    <= stim_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      pass    <= pass_nxt;
      mask    <= mask_nxt;
      err     <= err_nxt;
      ffv     <= ffv_nxt;
      ffvalid <= ffvalid_nxt;
    end
  end

  assign bus.a1 = stim[0];
  assign bus.b1 = stim[1];
  assign bus.a2 = stim[2];
  assign bus.b2 = stim[3];
  assign bus.a3 = stim[4];
  assign bus.b3 = stim[5];
  assign bus.a4 = stim[6];
  assign bus.b4 = stim[7];

  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.fail_mask        = mask;
  assign bus.err_count        = err;
  assign bus.first_fail_vec   = ffv;
  assign bus.first_fail_valid = ffvalid;

endmodule

// File: doc/nor_package_tester.md
Name: nor_package_tester

Overview:
- Self-checking sequencer for a quad 2-input NOR device, either the library gate model or a physical 74LS02 on the board.
- Drives all 256 combinations of the eight gate inputs and waits a programmable settle time per vector.
- Samples the four outputs through a synchroniser and compares each against the expected NOR.
- Reports pass/fail, a per-gate failure mask, an error count and the first failing vector.
- Sits between a board-level start/status interface and the device under test.

Parameters:
SETTLE_CYCLES, 8, clock cycles each vector is held before checking. Must be >= 3 (two synchroniser stages plus one) plus ceil(gate delay / clock period).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a test run; sampled only in IDLE
abort  input  1  cancel a run in progress
a1,b1,a2,b2,a3,b3,a4,b4  output  1 each  stimulus to the DUT gate inputs
y1,y2,y3,y4  input  1 each  DUT gate outputs (asynchronous to clk)
busy  output  1  run in progress
done  output  1  one-cycle pulse at run completion
pass  output  1  last completed run had zero errors
fail_mask  output  4  bit k-1 set if gate k mismatched on any vector
err_count  output  9  number of vectors with at least one mismatching gate (0..256)
first_fail_vec  output  8  vector index of the first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset (asynchronous, any state): state IDLE; all a/b = 0; busy, done, pass, first_fail_valid = 0; fail_mask, err_count, first_fail_vec = 0; vector and settle counters = 0; synchroniser flops = 0.
- Vector mapping (vec is an 8-bit counter): a1=vec[0], b1=vec[1], a2=vec[2], b2=vec[3], a3=vec[4], b3=vec[5], a4=vec[6], b4=vec[7]. Outputs are registered and change only on state transitions.
- Synchroniser: y1..y4 each pass through 2 flops. CHECK uses the synchronised values.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 and abort=0 at an edge →
  - clear fail_mask, err_count, first_fail_vec, first_fail_valid and pass;
  - vec=0, drive vector 0;
  - settle counter = SETTLE_CYCLES-1; busy=1; go to SETTLE.
- SETTLE: decrement the counter each cycle; when it is 0, go to CHECK. Duration is exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - exp_k = ~(a_k | b_k); m_k = sync_y_k ^ exp_k.
  - fail_mask |= m.
  - If m != 0: err_count += 1. If first_fail_valid = 0, also first_fail_vec = vec and first_fail_valid = 1.
  - If vec = 255: go to DONE.
  - Otherwise: vec += 1, drive the new vector, reload the settle counter, go to SETTLE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0), all a/b driven 0, return to IDLE. pass and the result registers hold until the next start or reset.
- Timing: start sampled at edge t0 → done high in the cycle following edge t0 + 256*(SETTLE_CYCLES+1). For the default, that edge is t0+2304.
- abort while busy (SETTLE or CHECK):
  - next state IDLE; busy=0; a/b=0; done not pulsed; pass=0;
  - fail_mask, err_count and first_fail_* retain their partial values.
  - abort has priority over CHECK updates in the same cycle.
- start while busy: ignored. start and abort together in IDLE: remain in IDLE.
- err_count cannot exceed 256, so there is no saturation logic.

Test Plan:
1. Good DUT: library NOR model, DELAY=10, clk 100 MHz, default parameter. Pulse start → done at edge t0+2304; pass=1, err_count=0, fail_mask=0000, first_fail_valid=0. busy high exactly from t0 until DONE.
2. y3 forced to 0 → err_count=64, fail_mask=0100, first_fail_vec=0x00, pass=0.
3. y4 forced to 1 → err_count=192, fail_mask=1000, first_fail_vec=0x40.
4. y1 inverted (OR behaviour) → err_count=256, fail_mask=0001, first_fail_vec=0x00. Separately, SETTLE_CYCLES=3 with DUT DELAY=50 ns → err_count>0 and pass=0 (insufficient settle is detected).
5. abort asserted 100 cycles after start → next cycle busy=0 and all a/b=0; done never pulses; pass=0. A following start completes with pass=1.
6. Reset asserted mid-run (asynchronous, between edges) → all outputs at reset values immediately, without a clock edge. A second start pulse while busy changes nothing; the run still completes at t0+2304.
